regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle datapath register file.
- Generalised in width and depth; writes on the rising edge; write-first bypass to both read ports; configurable link register for jal.
- Adds a per-register busy scoreboard so the pipelined datapath can detect RAW hazards and stall.

Parameters:
W, 32, data width of each register
DEPTH, 32, number of architectural registers; power of two, ≥ 2
AW, $clog2(DEPTH), register address width (derived; do not override)
LINK_REG, DEPTH-1, index written when jal_ra is asserted
ZERO_REG_EN, 1, 1 = register 0 is hardwired zero

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
regwrite  input  1  write enable
jal_ra  input  1  redirect the write to LINK_REG
wr_addr  input  AW  write address; ignored when jal_ra=1
wr_data  input  W  write data
rr1_addr  input  AW  read port 1 address
rr2_addr  input  AW  read port 2 address
rdata1  output  W  read port 1 data (combinational)
rdata2  output  W  read port 2 data (combinational)
rbusy1  output  1  register at rr1_addr has a pending producer
rbusy2  output  1  register at rr2_addr has a pending producer
reserve_en  input  1  issue stage claims a destination register
reserve_addr  input  AW  register being claimed
busy_count  output  AW+1  number of registers currently marked busy

Behaviour:
- Reset:
  - reset_n=0 clears every register and every busy bit immediately, with no clock needed.
  - While reset_n=0: rdata*=0, rbusy*=0, busy_count=0. Reset overrides any write or reserve in flight.
- Effective write address: ea = jal_ra ? LINK_REG : wr_addr.
- Write qualification:
  - A write happens when regwrite=1, except when ZERO_REG_EN=1 and ea=0. That case is silently dropped.
  - jal_ra with regwrite=0 does nothing.
- Write timing: the array updates on the rising edge of clock.
- Read path (combinational):
  - rdataN = wr_data when a qualified write targets rrN_addr in the same cycle (write-first bypass).
  - Otherwise rdataN = array[rrN_addr].
  - Reading register 0 with ZERO_REG_EN=1 always returns 0.
- Scoreboard (one busy bit per register), updated on the rising edge:
  - A qualified write to ea clears busy[ea].
  - reserve_en=1 sets busy[reserve_addr]. It is ignored for register 0 when ZERO_REG_EN=1.
  - Reserve and write to the same register in the same cycle: reserve wins, so the bit ends at 1 (a newer producer is pending).
  - Reserve of an already-busy register: the bit stays 1, with no error.
- Busy read (combinational, with bypass):
  - rbusyN = busy[rrN_addr], masked to 0 when a qualified write to rrN_addr occurs this cycle and no reserve to that register occurs this cycle.
- busy_count:
  - Registered population count of the busy bits.
  - Updated on the same edge as the busy bits, so it reflects the post-edge state.
  - Range 0..DEPTH (DEPTH reachable only with ZERO_REG_EN=0), hence AW+1 bits.
- No internal address range check is needed: DEPTH is a power of two, so every AW-bit address is valid.

Decomposition:
- Shared package regfile_pkg:
  - localparam defaults REG_W=32, REG_DEPTH=32, LINK_REG_IDX=31, ZERO_REG_IDX=0.
  - Function for the address width.
- Sub-module regfile_scoreboard:
  - Contains the busy-bit vector, set/clear priority, busy_count register and the bypassed rbusy lookups.
- The top level contains the storage array, write qualification and data bypass.

Test Plan:
- Reset: hold reset_n=0 while driving regwrite=1, wr_addr=5, wr_data=0xDEADBEEF for 3 edges. Release, read rr1_addr=5 -> rdata1=0, busy_count=0. Assert reset_n=0 mid-cycle after writing 0x1234 to r7 -> rdata for r7 reads 0 immediately, before the next edge.
- Write/bypass: regwrite=1, wr_addr=3, wr_data=0xA5A5A5A5, rr1_addr=3 in the same cycle -> rdata1=0xA5A5A5A5 before the edge. After the edge with regwrite=0 -> still 0xA5A5A5A5. Write 0xFFFFFFFF to r0 -> r0 reads 0.
- Link write: jal_ra=1, regwrite=1, wr_addr=9, wr_data=0x00400008 -> r31=0x00400008 and r9 unchanged. jal_ra=1 with regwrite=0 -> r31 unchanged.
- Scoreboard: reserve r4, then reserve r6 -> busy_count=2 and rbusy1=1 for rr1_addr=4. Write r4 with rr1_addr=4 -> rbusy1=0 in the same cycle; busy_count=1 after the edge.
- Simultaneous events:
  - Reserve r8 and write r8 in one cycle (r8 busy beforehand) -> busy[8]=1 and busy_count unchanged.
  - Reserve r0 -> busy_count unchanged.
- Parameter sweep: W=16, DEPTH=8, LINK_REG=7 -> jal write lands in r7, busy_count is 4 bits wide, and reserving r1..r7 gives busy_count=7.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Imported by regfile_sb and regfile_scoreboard.
package regfile_pkg;

  localparam int unsigned REG_W        = 32;
  localparam int unsigned REG_DEPTH    = 32;
  localparam int unsigned LINK_REG_IDX = 31;
  localparam int unsigned ZERO_REG_IDX = 0;

  // Bits needed to address depth entries (minimum 1).
  function automatic int unsigned addr_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection, with a registered
// population count and write-bypassed busy lookups.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH       = REG_DEPTH,
  parameter int unsigned AW          = addr_width(DEPTH),
  parameter bit          ZERO_REG_EN = 1'b1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          reserve_en,
  input  logic [AW-1:0] reserve_addr,
  input  logic [AW-1:0] rr1_addr,
  input  logic [AW-1:0] rr2_addr,
  output logic          rbusy1,
  output logic          rbusy2,
  output logic [AW:0]   busy_count
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;
  logic             rsv_en;

  assign rsv_en = reserve_en & ~(ZERO_REG_EN && (reserve_addr == AW'(ZERO_REG_IDX)));

  // Reserve is applied after the clear so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[wr_addr]      = 1'b0;
    if (rsv_en) busy_d[reserve_addr] = 1'b1;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  function automatic logic busy_lookup(input logic [AW-1:0] addr);
    logic cleared;
    cleared = wr_en && (wr_addr == addr) && !(rsv_en && (reserve_addr == addr));
    return busy_q[addr] & ~cleared;
  endfunction

  assign rbusy1     = busy_lookup(rr1_addr);
  assign rbusy2     = busy_lookup(rr2_addr);
  assign busy_count = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-first bypass, jal link-register
// redirect and a busy scoreboard for pipeline stall detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned W           = REG_W,
  parameter int unsigned DEPTH       = REG_DEPTH,
  parameter int unsigned AW          = addr_width(DEPTH),
  parameter int unsigned LINK_REG    = DEPTH - 1,
  parameter bit          ZERO_REG_EN = 1'b1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          regwrite,
  input  logic          jal_ra,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rr1_addr,
  input  logic [AW-1:0] rr2_addr,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2,
  output logic          rbusy1,
  output logic          rbusy2,
  input  logic          reserve_en,
  input  logic [AW-1:0] reserve_addr,
  output logic [AW:0]   busy_count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] ea;
  logic          wr_en;

  assign ea = jal_ra ? AW'(LINK_REG) : wr_addr;

  // Gating with reset_n keeps the bypass from leaking wr_data during reset.
  assign wr_en = regwrite & reset_n & ~(ZERO_REG_EN && (ea == AW'(ZERO_REG_IDX)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[ea] <= wr_data;
    end
  end

  function automatic logic [W-1:0] read_port(input logic [AW-1:0] addr);
    logic [W-1:0] val;
    if (!reset_n) begin
      val = '0;
    end else if (wr_en && (ea == addr)) begin
      val = wr_data;
    end else if (ZERO_REG_EN && (addr == AW'(ZERO_REG_IDX))) begin
      val = '0;
    end else begin
      val = mem_q[addr];
    end
    return val;
  endfunction

  assign rdata1 = read_port(rr1_addr);
  assign rdata2 = read_port(rr2_addr);

  regfile_scoreboard #(
    .DEPTH       (DEPTH),
    .AW          (AW),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_scoreboard (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (ea),
    .reserve_en   (reserve_en),
    .reserve_addr (reserve_addr),
    .rr1_addr     (rr1_addr),
    .rr2_addr     (rr2_addr),
    .rbusy1       (rbusy1),
    .rbusy2       (rbusy2),
    .busy_count   (busy_count)
  );

endmodule
